// File: rtl/vram_pixel_fetch.sv
// rtl/vram_pixel_fetch.sv - line-buffered 32x32 RGB332 image fetch and scaler for the VGA raster
// Optional build macro VRAM_TESTPAT_EN adds test_en_i and a colour-bar pattern; SCALE must be a power of 2.
module vram_pixel_fetch #(
  parameter int          IMG_W      = 32,
  parameter int          IMG_H      = 32,
  parameter int          SCALE      = 8,
  parameter int          X0         = 192,
  parameter int          Y0         = 112,
  parameter int          BASE_ADDR  = 0,
  parameter int          ADDR_W     = 8,
  parameter logic [23:0] BORDER_RGB = 24'h000000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              pix_en_i,
  input  logic [9:0]        x_i,
  input  logic [9:0]        y_i,
  input  logic              video_on_i,
  input  logic              hblank_start_i,
`ifdef VRAM_TESTPAT_EN
  input  logic              test_en_i,
`endif
  output logic              mem_rd_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [31:0]       mem_rdata_i,
  output logic [7:0]        red_o,
  output logic [7:0]        green_o,
  output logic [7:0]        blue_o,
  output logic              underrun_o
);

  localparam int WPR   = IMG_W / 4;
  localparam int KW    = (WPR > 1) ? $clog2(WPR) : 1;
  localparam int SHIFT = $clog2(SCALE);
  localparam int CW    = $clog2(IMG_W);
  localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic [10:0]   X_LO   = 11'(X0);
  localparam logic [10:0]   X_HI   = 11'(X0 + IMG_W * SCALE);
  localparam logic [10:0]   Y_LO   = 11'(Y0);
  localparam logic [10:0]   Y_HI   = 11'(Y0 + IMG_H * SCALE);
  localparam logic [KW-1:0] K_LAST = KW'(WPR - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [KW-1:0]     k_q;
  logic              rd_vld_q;
  logic [KW-1:0]     rd_idx_q;
  logic [31:0]       line_q [WPR];
  logic [23:0]       rgb_q;
  logic              underrun_q;

  logic              test_en;
  logic              start;
  logic              kill;

`ifdef VRAM_TESTPAT_EN
  assign test_en = test_en_i;
`else
  assign test_en = 1'b0;
`endif

  // Row selection for the line that follows the current horizontal blank
  logic [9:0]        ny;
  logic [10:0]       ny_ext;
  logic              row_hit;
  logic [RW-1:0]     row;
  logic [ADDR_W-1:0] row_base;

  assign ny       = (y_i == 10'd524) ? 10'd0 : y_i + 10'd1;
  assign ny_ext   = {1'b0, ny};
  assign row_hit  = (ny_ext >= Y_LO) && (ny_ext < Y_HI);
  assign row      = RW'((ny_ext - Y_LO) >> SHIFT);
  assign row_base = ADDR_W'(BASE_ADDR) + ADDR_W'(row) * ADDR_W'(WPR);

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    kill    = 1'b0;
    if (hblank_start_i) begin
      kill = 1'b1;
      if (row_hit) begin
        state_d = FETCH;
        start   = 1'b1;
      end else begin
        state_d = IDLE;
      end
    end else begin
      case (state_q)
        FETCH:   if (k_q == K_LAST) state_d = DRAIN;
        DRAIN:   state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
    if (test_en) begin
      state_d = IDLE;
      start   = 1'b0;
    end
  end

  assign mem_rd_o   = (state_q == FETCH) && !test_en;
  assign mem_addr_o = addr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      k_q      <= '0;
      rd_vld_q <= 1'b0;
      rd_idx_q <= '0;
    end else begin
      state_q  <= state_d;
      // A request issued on the aborting edge must not land in the buffer
      rd_vld_q <= mem_rd_o && !kill;
      rd_idx_q <= k_q;
      if (start) begin
        addr_q <= row_base;
        k_q    <= '0;
      end else if (mem_rd_o) begin
        addr_q <= addr_q + ADDR_W'(1);
        k_q    <= k_q + KW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rd_vld_q && !kill) line_q[rd_idx_q] <= mem_rdata_i;
  end

  logic [10:0]   x_ext;
  logic [10:0]   y_ext;
  logic [10:0]   dx;
  logic [CW-1:0] col;
  logic          in_win;
  logic [31:0]   word_sel;
  logic [7:0]    pix_byte;
  logic [23:0]   pix_rgb;

  assign x_ext    = {1'b0, x_i};
  assign y_ext    = {1'b0, y_i};
  assign dx       = x_ext - X_LO;
  assign col      = CW'(dx >> SHIFT);
  assign in_win   = (x_ext >= X_LO) && (x_ext < X_HI) && (y_ext >= Y_LO) && (y_ext < Y_HI);
  assign word_sel = line_q[col[CW-1:2]];
  assign pix_byte = word_sel[{col[1:0], 3'b000} +: 8];
  assign pix_rgb  = {pix_byte[7:5], pix_byte[7:5], pix_byte[7:6],
                     pix_byte[4:2], pix_byte[4:2], pix_byte[4:3],
                     {4{pix_byte[1:0]}}};

`ifdef VRAM_TESTPAT_EN
  logic [2:0] bar;
  assign bar = 3'(dx >> 5);
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rgb_q      <= 24'h000000;
      underrun_q <= 1'b0;
    end else if (pix_en_i) begin
      if (!video_on_i) begin
        rgb_q <= 24'h000000;
      end else if (!in_win) begin
        rgb_q <= BORDER_RGB;
`ifdef VRAM_TESTPAT_EN
      end else if (test_en) begin
        rgb_q <= {{8{bar[2]}}, {8{bar[1]}}, {8{bar[0]}}};
`endif
      end else if (state_q != IDLE) begin
        rgb_q      <= BORDER_RGB;
        underrun_q <= 1'b1;
      end else begin
        rgb_q <= pix_rgb;
      end
    end
  end

  assign red_o      = rgb_q[23:16];
  assign green_o    = rgb_q[15:8];
  assign blue_o     = rgb_q[7:0];
  assign underrun_o = underrun_q;

endmodule

// File: tb/tb_vram_pixel_fetch.sv
// tb/tb_vram_pixel_fetch.sv - self-checking bench for vram_pixel_fetch with a 1-clk-latency RAM model
module tb_vram_pixel_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_en;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        video_on;
  logic        hblank_start;
  logic        test_en;
  logic        mem_rd;
  logic [7:0]  mem_addr;
  logic [31:0] mem_rdata;
  logic [7:0]  red;
  logic [7:0]  green;
  logic [7:0]  blue;
  logic        underrun;

  logic [31:0] mem [256];
  logic [23:0] sb [$];
  int          checks   = 0;
  int          failures = 0;

  typedef struct {
    logic [9:0]  vx;
    logic [9:0]  vy;
    logic        vo;
    logic [23:0] rgb;
  } vec_t;

  vec_t vt [14];

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  vram_pixel_fetch dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .pix_en_i       (pix_en),
    .x_i            (x),
    .y_i            (y),
    .video_on_i     (video_on),
    .hblank_start_i (hblank_start),
`ifdef VRAM_TESTPAT_EN
    .test_en_i      (test_en),
`endif
    .mem_rd_o       (mem_rd),
    .mem_addr_o     (mem_addr),
    .mem_rdata_i    (mem_rdata),
    .red_o          (red),
    .green_o        (green),
    .blue_o         (blue),
    .underrun_o     (underrun)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic pix(input string name, input logic [9:0] px, input logic [9:0] py,
                     input logic vo, input logic [23:0] exp);
    logic [23:0] e;
    @(negedge clk);
    x = px; y = py; video_on = vo; pix_en = 1'b1;
    sb.push_back(exp);
    @(negedge clk);
    pix_en = 1'b0;
    if (sb.size() == 0) begin
      chk({name, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk(name, {8'h00, red, green, blue}, {8'h00, e});
    end
  endtask

  task automatic pulse(input logic [9:0] py);
    @(negedge clk);
    hblank_start = 1'b1; y = py;
    @(negedge clk);
    hblank_start = 1'b0;
  endtask

  task automatic fetch_check(input string name, input logic [7:0] base);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("%s_rd%0d", name, k), mem_rd, 1);
      chk($sformatf("%s_addr%0d", name, k), mem_addr, base + 8'(k));
      @(negedge clk);
    end
    chk({name, "_rd_end"}, mem_rd, 0);
  endtask

  task automatic no_fetch(input string name, input logic [9:0] py);
    int highs;
    highs = 0;
    pulse(py);
    for (int i = 0; i < 12; i++) begin
      if (mem_rd) highs++;
      @(negedge clk);
    end
    chk(name, highs, 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0]  = 32'h000000E0;
    mem[1]  = 32'hFF031C92;
    mem[2]  = 32'h000000E3;
    mem[7]  = 32'h4A000000;
    mem[8]  = 32'h000000E0;
    mem[16] = 32'h0000001C;

    vt[0]  = '{10'd192, 10'd112, 1'b1, 24'hFF0000};
    vt[1]  = '{10'd199, 10'd112, 1'b1, 24'hFF0000};
    vt[2]  = '{10'd200, 10'd112, 1'b1, 24'h000000};
    vt[3]  = '{10'd224, 10'd112, 1'b1, 24'h9292AA};
    vt[4]  = '{10'd232, 10'd112, 1'b1, 24'h00FF00};
    vt[5]  = '{10'd240, 10'd112, 1'b1, 24'h0000FF};
    vt[6]  = '{10'd255, 10'd112, 1'b1, 24'hFFFFFF};
    vt[7]  = '{10'd256, 10'd112, 1'b1, 24'hFF00FF};
    vt[8]  = '{10'd447, 10'd112, 1'b1, 24'h4949AA};
    vt[9]  = '{10'd448, 10'd112, 1'b1, 24'h000000};
    vt[10] = '{10'd191, 10'd112, 1'b1, 24'h000000};
    vt[11] = '{10'd192, 10'd112, 1'b0, 24'h000000};
    vt[12] = '{10'd192, 10'd111, 1'b1, 24'h000000};
    vt[13] = '{10'd192, 10'd368, 1'b1, 24'h000000};

    rst = 1'b1; pix_en = 1'b0; x = '0; y = '0; video_on = 1'b0;
    hblank_start = 1'b0; test_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_rgb", {red, green, blue}, 0);
    chk("rst_underrun", underrun, 0);
    rst = 1'b0;

    pulse(10'd111);
    fetch_check("row0", 8'd0);

    for (int i = 0; i < 14; i++)
      pix($sformatf("vec%0d", i), vt[i].vx, vt[i].vy, vt[i].vo, vt[i].rgb);
    pix("row0_y119", 10'd192, 10'd119, 1'b1, 24'hFF0000);

    pix("hold_pre", 10'd192, 10'd112, 1'b1, 24'hFF0000);
    @(negedge clk);
    x = 10'd200;
    @(negedge clk);
    chk("hold", {red, green, blue}, 24'hFF0000);

    no_fetch("no_fetch_y523", 10'd523);
    pix("border_y523", 10'd192, 10'd523, 1'b0, 24'h000000);
    no_fetch("no_fetch_y524", 10'd524);

    pulse(10'd119);
    chk("abort_addr8", mem_addr, 8);
    @(negedge clk);
    chk("abort_addr9", mem_addr, 9);
    @(negedge clk);
    chk("abort_addr10", mem_addr, 10);
    hblank_start = 1'b1; y = 10'd127;
    @(negedge clk);
    hblank_start = 1'b0;
    fetch_check("abort_row2", 8'd16);
    pix("row2_x192", 10'd192, 10'd128, 1'b1, 24'h00FF00);
    pix("row2_x200", 10'd200, 10'd128, 1'b1, 24'h000000);
    chk("no_underrun_yet", underrun, 0);

    pulse(10'd127);
    pix("underrun_pix", 10'd192, 10'd128, 1'b1, 24'h000000);
    chk("underrun_set", underrun, 1);
    repeat (10) @(negedge clk);
    pix("after_underrun", 10'd192, 10'd128, 1'b1, 24'h00FF00);
    chk("underrun_sticky", underrun, 1);

    pulse(10'd111);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_mem_rd", mem_rd, 0);
    chk("midrst_addr", mem_addr, 0);
    chk("midrst_rgb", {red, green, blue}, 0);
    chk("midrst_underrun", underrun, 0);
    pulse(10'd111);
    fetch_check("post_rst", 8'd0);
    pix("post_rst_pix", 10'd192, 10'd112, 1'b1, 24'hFF0000);
    chk("post_rst_underrun", underrun, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
